// File: rtl/vga_pkg.sv
// Shared VGA pixel-source definitions: RGB565 palette, screen geometry, bounce-axis helpers.
// Pure declarations, no state.
package vga_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;
  localparam logic [9:0] NO_REQ = 10'h3FF;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] PURPLE = 16'hF81F;
  localparam logic [15:0] GRAY   = 16'hD69A;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
  } axis_t;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RED;
      3'd1:    c = ORANGE;
      3'd2:    c = YELLOW;
      3'd3:    c = GREEN;
      3'd4:    c = CYAN;
      3'd5:    c = BLUE;
      3'd6:    c = PURPLE;
      default: c = GRAY;
    endcase
    return c;
  endfunction

  // One bounce move along one axis; a wall hit clamps to the wall and reverses.
  function automatic axis_t axis_step(input axis_t cur, input logic [10:0] size,
                                      input logic [10:0] step, input logic [10:0] limit);
    axis_t       nxt;
    logic [10:0] pos11;
    nxt   = cur;
    pos11 = {1'b0, cur.pos};
    if (cur.dir == DIR_POS) begin
      if (pos11 + size + step > limit) begin
        nxt.pos = 10'(limit - size);
        nxt.dir = DIR_NEG;
      end else begin
        nxt.pos = 10'(pos11 + step);
      end
    end else begin
      if (pos11 < step) begin
        nxt.pos = 10'd0;
        nxt.dir = DIR_POS;
      end else begin
        nxt.pos = 10'(pos11 - step);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_bounce_mover.sv
// Box position state: frame divider plus per-axis bounce direction and position registers.
// Moves only on a frame_tick cycle, so position is stable across every active frame.
module vga_bounce_mover
  import vga_pkg::*;
#(
  parameter int H_VALID   = H_VALID_DEF,
  parameter int V_VALID   = V_VALID_DEF,
  parameter int BOX_W     = 32,
  parameter int BOX_H     = 32,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       frame_tick,
  input  logic       pause,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [10:0] W11      = 11'(BOX_W);
  localparam logic [10:0] H11      = 11'(BOX_H);
  localparam logic [10:0] S11      = 11'(STEP);
  localparam logic [10:0] HV11     = 11'(H_VALID);
  localparam logic [10:0] VV11     = 11'(V_VALID);

  logic [7:0] div;
  axis_t      ax;
  axis_t      ay;
  logic       tick_en;

  assign tick_en = frame_tick && !pause;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div <= 8'd0;
      ax  <= '{pos: 10'd0, dir: DIR_POS};
      ay  <= '{pos: 10'd0, dir: DIR_POS};
    end else if (tick_en) begin
      if (div == DIV_LAST) begin
        div <= 8'd0;
        ax  <= axis_step(ax, W11, S11, HV11);
        ay  <= axis_step(ay, H11, S11, VV11);
      end else begin
        div <= div + 8'd1;
      end
    end
  end

  assign box_x = ax.pos;
  assign box_y = ay.pos;

endmodule

// File: rtl/vga_pic_bounce.sv
// Pixel source: 8 colour bars with a bouncing solid box, RGB565 out.
// pix_data registered, 1 cycle after pix_x/pix_y, one pixel per clock with no stalls.
module vga_pic_bounce
  import vga_pkg::*;
#(
  parameter int          H_VALID   = H_VALID_DEF,
  parameter int          V_VALID   = V_VALID_DEF,
  parameter int          BOX_W     = 32,
  parameter int          BOX_H     = 32,
  parameter int          STEP      = 2,
  parameter int          FRAME_DIV = 1,
  parameter logic [15:0] BOX_COLOR = WHITE
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pause,
  output logic [15:0] pix_data,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic        frame_tick
);

  localparam int          BAR_W  = H_VALID / 8;
  localparam logic [10:0] HV11   = 11'(H_VALID);
  localparam logic [10:0] VV11   = 11'(V_VALID);
  localparam logic [10:0] W11    = 11'(BOX_W);
  localparam logic [10:0] H11    = 11'(BOX_H);
  localparam logic [9:0]  H_LAST = 10'(H_VALID - 1);
  localparam logic [9:0]  V_LAST = 10'(V_VALID - 1);

  logic [10:0] px, py, bx, by;
  logic        in_range, in_box, frame_end;
  logic [2:0]  bar_sel;
  logic [15:0] pix_next;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};
  assign bx = {1'b0, box_x};
  assign by = {1'b0, box_y};

  assign in_range  = (pix_x != NO_REQ) && (pix_y != NO_REQ) && (px < HV11) && (py < VV11);
  assign in_box    = (px >= bx) && (px < bx + W11) && (py >= by) && (py < by + H11);
  assign frame_end = (pix_x == H_LAST) && (pix_y == V_LAST);

  // Bar index as a threshold chain keeps the divide out of the pixel path.
  always_comb begin
    bar_sel = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (px >= 11'(k * BAR_W)) bar_sel = 3'(k);
    end
  end

  always_comb begin
    pix_next = BLACK;
    if (in_range) pix_next = in_box ? BOX_COLOR : bar_color(bar_sel);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data   <= 16'd0;
      frame_tick <= 1'b0;
    end else begin
      pix_data   <= pix_next;
      frame_tick <= frame_end;
    end
  end

  vga_bounce_mover #(
    .H_VALID  (H_VALID),
    .V_VALID  (V_VALID),
    .BOX_W    (BOX_W),
    .BOX_H    (BOX_H),
    .STEP     (STEP),
    .FRAME_DIV(FRAME_DIV)
  ) u_mover (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .frame_tick(frame_tick),
    .pause     (pause),
    .box_x     (box_x),
    .box_y     (box_y)
  );

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Directed bench for vga_pic_bounce: default instance plus a FRAME_DIV=3 instance.
// Frame ends are issued directly as the (639,479) request to keep bounce runs short.
module tb_vga_pic_bounce;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  pix_x, pix_y;
  logic        pause, pause3;
  logic [15:0] pix_data, pix_data3;
  logic [9:0]  box_x, box_y, box_x3, box_y3;
  logic        frame_tick, frame_tick3;

  int total = 0;
  int bad   = 0;

  logic [15:0] bars [8] = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0,
                            16'h07FF, 16'h001F, 16'hF81F, 16'hD69A};

  always #20 vga_clk = ~vga_clk;

  vga_pic_bounce dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pause     (pause),
    .pix_data  (pix_data),
    .box_x     (box_x),
    .box_y     (box_y),
    .frame_tick(frame_tick)
  );

  vga_pic_bounce #(.FRAME_DIV(3)) dut3 (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pause     (pause3),
    .pix_data  (pix_data3),
    .box_x     (box_x3),
    .box_y     (box_y3),
    .frame_tick(frame_tick3)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic req(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    step();
  endtask

  task automatic frame_end();
    req(10'd639, 10'd479);
    req(10'h3FF, 10'h3FF);
  endtask

  initial begin
    int ticks;
    sys_rst_n = 1'b0;
    pix_x     = 10'h3FF;
    pix_y     = 10'h3FF;
    pause     = 1'b0;
    pause3    = 1'b0;
    step();
    step();
    chk("rst_pix", pix_data, 16'h0000);
    chk("rst_bx", {6'd0, box_x}, 16'd0);
    chk("rst_by", {6'd0, box_y}, 16'd0);
    chk("rst_tick", {15'd0, frame_tick}, 16'd0);
    sys_rst_n = 1'b1;
    step();

    req(10'd0, 10'd100);   chk("p0_100", pix_data, 16'hF800);
    req(10'd0, 10'd0);     chk("p0_0", pix_data, 16'hFFFF);
    req(10'd31, 10'd31);   chk("p31_31", pix_data, 16'hFFFF);
    req(10'd32, 10'd0);    chk("p32_0", pix_data, 16'hF800);
    req(10'd0, 10'd32);    chk("p0_32", pix_data, 16'hF800);

    req(10'h3FF, 10'd0);   chk("noreq_x", pix_data, 16'h0000);
    req(10'd0, 10'h3FF);   chk("noreq_y", pix_data, 16'h0000);
    req(10'd80, 10'd200);  chk("p80", pix_data, 16'hFC00);
    req(10'd79, 10'd200);  chk("p79", pix_data, 16'hF800);
    req(10'd639, 10'd200); chk("p639", pix_data, 16'hD69A);
    chk("no_tick", {15'd0, frame_tick}, 16'd0);
    req(10'd320, 10'd0);   chk("p320", pix_data, 16'h07FF);
    req(10'd640, 10'd200); chk("x640", pix_data, 16'h0000);
    req(10'd0, 10'd480);   chk("y480", pix_data, 16'h0000);

    // Three frames: last two active lines scanned back to back, then blanking.
    for (int f = 0; f < 3; f++) begin
      ticks = 0;
      for (int x = 0; x < 640; x++) begin
        req(10'(x), 10'd478);
        if (frame_tick) ticks++;
      end
      for (int x = 0; x < 640; x++) begin
        req(10'(x), 10'd479);
        if (frame_tick) ticks++;
        if (f == 0 && (x % 80) == 0) chk("bar_scan", pix_data, bars[x / 80]);
      end
      for (int b = 0; b < 160; b++) begin
        req(10'h3FF, 10'h3FF);
        if (frame_tick) ticks++;
      end
      chk("ticks_per_frame", 16'(ticks), 16'd1);
      chk("scan_bx", {6'd0, box_x}, 16'(2 * (f + 1)));
      chk("scan_by", {6'd0, box_y}, 16'(2 * (f + 1)));
    end

    req(10'd6, 10'd6);   chk("box_tl", pix_data, 16'hFFFF);
    req(10'd37, 10'd37); chk("box_br", pix_data, 16'hFFFF);
    req(10'd38, 10'd6);  chk("box_r", pix_data, 16'hF800);
    req(10'd5, 10'd6);   chk("box_l", pix_data, 16'hF800);
    req(10'd6, 10'd38);  chk("box_b", pix_data, 16'hF800);
    req(10'd6, 10'd5);   chk("box_t", pix_data, 16'hF800);

    for (int n = 4; n <= 611; n++) begin
      frame_end();
      case (n)
        224: chk("y_224", {6'd0, box_y}, 16'd448);
        225: chk("y_bot_clamp", {6'd0, box_y}, 16'd448);
        226: chk("y_226", {6'd0, box_y}, 16'd446);
        303: chk("x_606", {6'd0, box_x}, 16'd606);
        304: chk("x_608", {6'd0, box_x}, 16'd608);
        305: chk("x_right_clamp", {6'd0, box_x}, 16'd608);
        306: chk("x_back_606", {6'd0, box_x}, 16'd606);
        449: chk("y_0", {6'd0, box_y}, 16'd0);
        450: chk("y_top_clamp", {6'd0, box_y}, 16'd0);
        451: chk("y_down_2", {6'd0, box_y}, 16'd2);
        609: chk("x_0", {6'd0, box_x}, 16'd0);
        610: chk("x_left_clamp", {6'd0, box_x}, 16'd0);
        611: chk("x_right_2", {6'd0, box_x}, 16'd2);
        default: ;
      endcase
    end

    pause = 1'b1;
    req(10'd639, 10'd479);
    chk("pause_tick", {15'd0, frame_tick}, 16'd1);
    req(10'h3FF, 10'h3FF);
    chk("pause_bx", {6'd0, box_x}, 16'd2);
    chk("pause_by", {6'd0, box_y}, 16'd322);
    pause = 1'b0;

    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    pause3 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      req(10'd639, 10'd479);
      chk("div3_pause_tick", {15'd0, frame_tick3}, 16'd1);
      req(10'h3FF, 10'h3FF);
      chk("div3_pause_bx", {6'd0, box_x3}, 16'd0);
    end
    pause3 = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      frame_end();
      chk("div3_bx", {6'd0, box_x3}, (t == 3) ? 16'd2 : 16'd0);
      chk("div3_by", {6'd0, box_y3}, (t == 3) ? 16'd2 : 16'd0);
    end

    req(10'd2, 10'd2);   chk("div3_box", pix_data3, 16'hFFFF);
    req(10'd12, 10'd12); chk("pre_rst_box", pix_data, 16'hFFFF);
    chk("pre_rst_bx", {6'd0, box_x}, 16'd10);
    #5;
    sys_rst_n = 1'b0;
    #1;
    chk("async_pix", pix_data, 16'h0000);
    chk("async_bx", {6'd0, box_x}, 16'd0);
    chk("async_by", {6'd0, box_y}, 16'd0);
    chk("async_bx3", {6'd0, box_x3}, 16'd0);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    step();
    req(10'd0, 10'd0);  chk("post_rst_box", pix_data, 16'hFFFF);
    req(10'd40, 10'd0); chk("post_rst_bar", pix_data, 16'hF800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
